instr_reg_reader: RTL

//   Read-side sequencer for the instruction register stack. On a start command it walks
//   a programmed number of locations in increment, decrement or pseudo-random order.
//   It drives read_pointer, captures instruction_word and streams each entry out on a

---
 rtl/instr_register_pkg.sv | 38 +++
 rtl/instr_reg_reader_calc.sv | 11 +
 rtl/instr_reg_reader.sv | 107 ++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared instruction types, reader enums and the reference calculator
package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, POW} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [4:0] address_t;
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rezultat;
  } instruction_t;
  typedef enum logic [1:0] {ORD_INC, ORD_DEC, ORD_RAND} rd_order_t;
  typedef enum logic [2:0] {IDLE, ADDR, CAPTURE, PRESENT, DONE} reader_state_t;
  function automatic result_t calc_result(opcode_t opc, operand_t a, operand_t b);
    result_t ea, eb, p, base;
    ea = result_t'(a);
    eb = result_t'(b);
    p = 64'sd1;
    base = ea;
    // square-and-multiply; a negative exponent has no integer result and yields 0
    for (int i = 0; i < 31; i++) begin
      if (b[i]) p = p * base;
      base = base * base;
    end
    case (opc)
      PASSA:   calc_result = ea;
      PASSB:   calc_result = eb;
      ADD:     calc_result = ea + eb;
      SUB:     calc_result = ea - eb;
      MULT:    calc_result = ea * eb;
      DIV:     calc_result = (b == 0) ? '0 : ea / eb;
      MOD:     calc_result = (b == 0) ? '0 : ea % eb;
      POW:     calc_result = b[31] ? '0 : p;
      default: calc_result = '0;
    endcase
  endfunction
endpackage

// File: rtl/instr_reg_reader_calc.sv
// instr_result_calc: combinational expected-result generator (used with RESULT_CHECK_EN)
module instr_result_calc
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  result
);
  assign result = calc_result(opc, op_a, op_b);
endmodule

// File: rtl/instr_reg_reader.sv
// instr_reg_reader: sequenced read-out of the instruction register stack over valid/ready
// Optional result checking (mismatch, err_count) is built when RESULT_CHECK_EN is defined.
module instr_reg_reader
  import instr_register_pkg::*;
#(
  parameter int       DEPTH     = 32,
  parameter address_t LFSR_SEED = 5'h1F,
  parameter int       ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  address_t             start_addr,
  input  logic [5:0]           rd_count,
  input  logic [1:0]           rd_order,
  output address_t             read_pointer,
  input  instruction_t         instruction_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output instruction_t         out_word,
  output address_t             out_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count
);
  reader_state_t state;
  address_t addr, addr_nxt, lfsr, lfsr_nxt;
  logic [5:0] cnt;
  logic [1:0] ord;
  logic hs;
  assign hs = state == PRESENT && out_valid && out_ready;
  assign lfsr_nxt = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
  always_comb
    addr_nxt = ord == ORD_DEC  ? (addr == '0 ? address_t'(DEPTH - 1) : addr - 5'd1) :
               ord == ORD_RAND ? lfsr_nxt :
                                 (addr == address_t'(DEPTH - 1) ? '0 : addr + 5'd1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      read_pointer <= 5'h1F;
      out_valid    <= 1'b0;
      out_word     <= '0;
      out_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      lfsr         <= LFSR_SEED;
      cnt          <= '0;
      addr         <= '0;
      ord          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr         <= start_addr;
          read_pointer <= start_addr;
          cnt          <= rd_count;
          ord          <= rd_order;
          state        <= rd_count == 6'd0 ? DONE : ADDR;
          busy         <= rd_count != 6'd0;
          done         <= rd_count == 6'd0;
        end
        ADDR: state <= CAPTURE;
        CAPTURE: begin
          out_word  <= instruction_word;
          out_addr  <= addr;
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: if (hs) begin
          out_valid    <= 1'b0;
          cnt          <= cnt - 6'd1;
          addr         <= addr_nxt;
          read_pointer <= addr_nxt;
          lfsr         <= ord == ORD_RAND ? lfsr_nxt : lfsr;
          state        <= cnt == 6'd1 ? DONE : ADDR;
          busy         <= cnt != 6'd1;
          done         <= cnt == 6'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef RESULT_CHECK_EN
  result_t exp_res;
  instr_result_calc u_calc (
    .opc   (instruction_word.opc),
    .op_a  (instruction_word.op_a),
    .op_b  (instruction_word.op_b),
    .result(exp_res)
  );
  // mismatch is captured alongside out_word so it stays aligned with the presented entry
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      if (state == CAPTURE) mismatch <= exp_res != instruction_word.rezultat;
      if (hs && mismatch && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
`else
  assign mismatch  = 1'b0;
  assign err_count = '0;
`endif
endmodule
